// File: rtl/jtcop_objrom_slot_if.sv
// Object ROM slot bundle: object-engine request/response plus the SDRAM arbiter port.
// The slot block uses the slave view; the environment drives the master view.
interface jtcop_objrom_slot_if #(
    parameter int AW  = 17,
    parameter int SDW = 22
) ();
    logic           slot_cs;
    logic [AW-1:0]  slot_addr;
    logic [31:0]    slot_dout;
    logic           slot_ok;
    logic           sdram_req;
    logic [SDW-1:0] sdram_addr;
    logic           sdram_ack;
    logic           sdram_dst;
    logic [15:0]    sdram_din;

    modport slave (
        input  slot_cs, slot_addr, sdram_ack, sdram_dst, sdram_din,
        output slot_dout, slot_ok, sdram_req, sdram_addr
    );

    modport master (
        output slot_cs, slot_addr, sdram_ack, sdram_dst, sdram_din,
        input  slot_dout, slot_ok, sdram_req, sdram_addr
    );
endinterface

// File: rtl/jtcop_objrom_slot.sv
// Object ROM slot: caches the last 32-bit word, refilling it as two 16-bit SDRAM beats.
// Optional second entry with next-word prefetch when JTCOP_OBJROM_PREFETCH_EN is defined.
module jtcop_objrom_slot #(
    parameter int             AW     = 17,
    parameter int             SDW    = 22,
    parameter logic [SDW-1:0] OFFSET = 22'h0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    jtcop_objrom_slot_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_BEAT0 = 2'd2,
        ST_BEAT1 = 2'd3
    } state_t;

    // Word address -> first 16-bit SDRAM location; wraps modulo 2^SDW.
    function automatic logic [SDW-1:0] map_addr(input logic [AW-1:0] a);
        logic [SDW-1:0] w;
        w         = {SDW{1'b0}};
        w[AW:1]   = a;
        map_addr  = OFFSET + w;
    endfunction

    state_t         state_q,      state_d;
    logic           valid_q,      valid_d;
    logic [AW-1:0]  tag_q,        tag_d;
    logic [31:0]    data_q,       data_d;
    logic [AW-1:0]  req_addr_q,   req_addr_d;
    logic           sdram_req_q,  sdram_req_d;
    logic [SDW-1:0] sdram_addr_q, sdram_addr_d;

    logic hit_a_s;
    logic hit_s;
    logic start_dem_s;
    logic start_any_s;

`ifdef JTCOP_OBJROM_PREFETCH_EN
    logic           valid_b_q,  valid_b_d;
    logic [AW-1:0]  tag_b_q,    tag_b_d;
    logic [31:0]    data_b_q,   data_b_d;
    logic           pf_pend_q,  pf_pend_d;
    logic [AW-1:0]  pf_addr_q,  pf_addr_d;
    logic           pf_fetch_q, pf_fetch_d;
    logic           hit_b_s;
    logic           swap_s;
    logic           start_pf_s;

    assign hit_b_s    = bus.slot_cs & valid_b_q & (tag_b_q == bus.slot_addr);
    assign hit_s      = hit_a_s | hit_b_s;
    assign swap_s     = hit_b_s & ~hit_a_s;
    assign start_pf_s = pf_pend_q & ~start_dem_s & ~swap_s;
    assign start_any_s = start_dem_s | start_pf_s;
    assign bus.slot_dout = swap_s ? data_b_q : data_q;
`else
    assign hit_s       = hit_a_s;
    assign start_any_s = start_dem_s;
    assign bus.slot_dout = data_q;
`endif

    assign hit_a_s        = bus.slot_cs & valid_q & (tag_q == bus.slot_addr);
    assign start_dem_s    = bus.slot_cs & ~hit_s;
    assign bus.slot_ok    = hit_s;
    assign bus.sdram_req  = sdram_req_q;
    assign bus.sdram_addr = sdram_addr_q;

    // State register and datapath flops, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            valid_q      <= 1'b0;
            tag_q        <= {AW{1'b0}};
            data_q       <= 32'h0000_0000;
            req_addr_q   <= {AW{1'b0}};
            sdram_req_q  <= 1'b0;
            sdram_addr_q <= {SDW{1'b0}};
`ifdef JTCOP_OBJROM_PREFETCH_EN
            valid_b_q    <= 1'b0;
            tag_b_q      <= {AW{1'b0}};
            data_b_q     <= 32'h0000_0000;
            pf_pend_q    <= 1'b0;
            pf_addr_q    <= {AW{1'b0}};
            pf_fetch_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            tag_q        <= tag_d;
            data_q       <= data_d;
            req_addr_q   <= req_addr_d;
            sdram_req_q  <= sdram_req_d;
            sdram_addr_q <= sdram_addr_d;
`ifdef JTCOP_OBJROM_PREFETCH_EN
            valid_b_q    <= valid_b_d;
            tag_b_q      <= tag_b_d;
            data_b_q     <= data_b_d;
            pf_pend_q    <= pf_pend_d;
            pf_addr_q    <= pf_addr_d;
            pf_fetch_q   <= pf_fetch_d;
`endif
        end
    end

    // Next-state logic: strobes outside their own state are ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_any_s) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus.sdram_ack) begin
                    state_d = ST_BEAT0;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_BEAT0: begin
                if (bus.sdram_dst) begin
                    state_d = ST_BEAT1;
                end else begin
                    state_d = ST_BEAT0;
                end
            end
            ST_BEAT1: begin
                if (bus.sdram_dst) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BEAT1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output/datapath logic: request issue, beat capture, tag/valid update.
    always_comb begin
        valid_d      = valid_q;
        tag_d        = tag_q;
        data_d       = data_q;
        req_addr_d   = req_addr_q;
        sdram_req_d  = sdram_req_q;
        sdram_addr_d = sdram_addr_q;
`ifdef JTCOP_OBJROM_PREFETCH_EN
        valid_b_d    = valid_b_q;
        tag_b_d      = tag_b_q;
        data_b_d     = data_b_q;
        pf_pend_d    = pf_pend_q;
        pf_addr_d    = pf_addr_q;
        pf_fetch_d   = pf_fetch_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_dem_s) begin
                    // Clearing valid here keeps slot_ok low until both halves land.
                    req_addr_d   = bus.slot_addr;
                    sdram_req_d  = 1'b1;
                    sdram_addr_d = map_addr(bus.slot_addr);
                    valid_d      = 1'b0;
`ifdef JTCOP_OBJROM_PREFETCH_EN
                    pf_fetch_d   = 1'b0;
                    pf_pend_d    = 1'b0;
                end else if (swap_s) begin
                    tag_d        = tag_b_q;
                    data_d       = data_b_q;
                    valid_d      = valid_b_q;
                    tag_b_d      = tag_q;
                    data_b_d     = data_q;
                    valid_b_d    = valid_q;
                    pf_pend_d    = 1'b1;
                    pf_addr_d    = tag_b_q + 1'b1;
                end else if (start_pf_s) begin
                    req_addr_d   = pf_addr_q;
                    sdram_req_d  = 1'b1;
                    sdram_addr_d = map_addr(pf_addr_q);
                    valid_b_d    = 1'b0;
                    pf_fetch_d   = 1'b1;
                    pf_pend_d    = 1'b0;
`endif
                end else begin
                    sdram_req_d  = 1'b0;
                end
            end
            ST_REQ: begin
                if (bus.sdram_ack) begin
                    sdram_req_d = 1'b0;
                end else begin
                    sdram_req_d = 1'b1;
                end
            end
            ST_BEAT0: begin
                if (bus.sdram_dst) begin
`ifdef JTCOP_OBJROM_PREFETCH_EN
                    if (pf_fetch_q) begin
                        data_b_d[15:0] = bus.sdram_din;
                    end else begin
                        data_d[15:0]   = bus.sdram_din;
                    end
`else
                    data_d[15:0] = bus.sdram_din;
`endif
                end else begin
                    sdram_req_d = 1'b0;
                end
            end
            ST_BEAT1: begin
                if (bus.sdram_dst) begin
`ifdef JTCOP_OBJROM_PREFETCH_EN
                    if (pf_fetch_q) begin
                        data_b_d[31:16] = bus.sdram_din;
                        tag_b_d         = req_addr_q;
                        valid_b_d       = 1'b1;
                        pf_fetch_d      = 1'b0;
                    end else begin
                        data_d[31:16] = bus.sdram_din;
                        tag_d         = req_addr_q;
                        valid_d       = 1'b1;
                        pf_pend_d     = bus.slot_cs;
                        pf_addr_d     = req_addr_q + 1'b1;
                    end
`else
                    data_d[31:16] = bus.sdram_din;
                    tag_d         = req_addr_q;
                    valid_d       = 1'b1;
`endif
                end else begin
                    sdram_req_d = 1'b0;
                end
            end
            default: begin
                sdram_req_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_jtcop_objrom_slot.sv
// Bench for jtcop_objrom_slot: directed SDRAM traffic, expected requests and words
// are queued by the stimulus and retired by an independent monitor.
module tb_jtcop_objrom_slot;

    localparam int AW  = 17;
    localparam int SDW = 22;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    jtcop_objrom_slot_if #(.AW(AW), .SDW(SDW)) bus ();

    jtcop_objrom_slot #(.AW(AW), .SDW(SDW), .OFFSET(22'h0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp   = 0;
    int n_err   = 0;
    int req_cnt = 0;

    logic [SDW-1:0] exp_req_q[$];
    logic [31:0]    exp_ok_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (bus.sdram_req === 1'b1) seen = 1'b1;
            else tick();
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: got no sdram_req expected a request within 40 cycles", name);
        end
    endtask

    task automatic ack();
        bus.sdram_ack = 1'b1;
        tick();
        bus.sdram_ack = 1'b0;
    endtask

    task automatic beats(input logic [15:0] lo, input logic [15:0] hi);
        bus.sdram_dst = 1'b1;
        bus.sdram_din = lo;
        tick();
        bus.sdram_din = hi;
        tick();
        bus.sdram_dst = 1'b0;
        bus.sdram_din = 16'h0000;
    endtask

    // Monitor: retires one queued request per sdram_req rise and one word per new hit.
    logic           prev_req  = 1'b0;
    logic           prev_ok   = 1'b0;
    logic [AW-1:0]  prev_addr = 17'h0;
    initial begin
        forever begin
            @(negedge clk);
            if (bus.sdram_req === 1'b1 && !prev_req) begin
                req_cnt++;
                if (exp_req_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_req: got sdram_addr %h expected no request", bus.sdram_addr);
                end else begin
                    check("req_addr", {10'h0, bus.sdram_addr}, {10'h0, exp_req_q.pop_front()});
                end
            end
            if (bus.slot_ok === 1'b1 && !(prev_ok && prev_addr == bus.slot_addr)) begin
                if (exp_ok_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_ok: got slot_ok for addr %h expected none", bus.slot_addr);
                end else begin
                    check("ok_dout", bus.slot_dout, exp_ok_q.pop_front());
                end
            end
            prev_req  = (bus.sdram_req === 1'b1);
            prev_ok   = (bus.slot_ok === 1'b1);
            prev_addr = bus.slot_addr;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before 500us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  saved;
        bit  bad;
        bus.slot_cs   = 1'b0;
        bus.slot_addr = 17'h0;
        bus.sdram_ack = 1'b0;
        bus.sdram_dst = 1'b0;
        bus.sdram_din = 16'h0000;
        repeat (3) tick();
        check("rst_req",  {31'h0, bus.sdram_req}, 32'h0);
        check("rst_addr", {10'h0, bus.sdram_addr}, 32'h0);
        check("rst_dout", bus.slot_dout, 32'h0);

        // 1: demand miss, two beats, word assembled low-half first
        exp_req_q.push_back(22'h20);
        exp_ok_q.push_back(32'h7856_3412);
        rst_n         = 1'b1;
        bus.slot_cs   = 1'b1;
        bus.slot_addr = 17'h00010;
        check("ok_before_fill", {31'h0, bus.slot_ok}, 32'h0);
        wait_req("t1_req");
        ack();
        check("req_drop_after_ack", {31'h0, bus.sdram_req}, 32'h0);
        bus.sdram_dst = 1'b1;
        bus.sdram_din = 16'h3412;
        tick();
        check("ok_mid_fill", {31'h0, bus.slot_ok}, 32'h0);
        bus.sdram_din = 16'h7856;
        tick();
        bus.sdram_dst = 1'b0;
        check("t1_ok", {31'h0, bus.slot_ok}, 32'h1);
        tick();

        // 2: repeat hit, zero latency, no SDRAM traffic
        bus.slot_cs = 1'b0;
        tick();
        check("ok_cs_low", {31'h0, bus.slot_ok}, 32'h0);
        saved = req_cnt;
        exp_ok_q.push_back(32'h7856_3412);
        bus.slot_cs = 1'b1;
        #1;
        check("t2_hit_same_cycle", {31'h0, bus.slot_ok}, 32'h1);
        repeat (5) tick();
        check("t2_no_req", req_cnt, saved);

        // 3: arbiter stalls 20 cycles, request must hold
        exp_req_q.push_back(22'h24);
        exp_ok_q.push_back(32'h2222_1111);
        bus.slot_addr = 17'h00012;
        wait_req("t3_req");
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.sdram_req !== 1'b1 || bus.sdram_addr !== 22'h24 || bus.slot_ok !== 1'b0) bad = 1'b1;
            tick();
        end
        check("t3_hold_stable", {31'h0, bad}, 32'h0);
        ack();
        beats(16'h1111, 16'h2222);
        tick();

        // 4: address moves after ack; fill tags the old address, then refetch
        exp_req_q.push_back(22'h20);
        bus.slot_addr = 17'h00010;
        wait_req("t4_req_a");
        ack();
        bus.slot_addr = 17'h00011;
        exp_req_q.push_back(22'h22);
        exp_ok_q.push_back(32'hDDDD_CCCC);
        beats(16'hAAAA, 16'hBBBB);
        check("t4_stale_fill_no_ok", {31'h0, bus.slot_ok}, 32'h0);
        wait_req("t4_req_b");
        ack();
        check("t4_ok_before_second_fill", {31'h0, bus.slot_ok}, 32'h0);
        beats(16'hCCCC, 16'hDDDD);
        check("t4_ok_after_fill", {31'h0, bus.slot_ok}, 32'h1);
        tick();

        // 5: reset during BEAT0; later strobes are strays
        exp_req_q.push_back(22'h40);
        bus.slot_addr = 17'h00020;
        wait_req("t5_req");
        ack();
        rst_n = 1'b0;
        tick();
        check("t5_req_dropped", {31'h0, bus.sdram_req}, 32'h0);
        check("t5_ok_cleared",  {31'h0, bus.slot_ok}, 32'h0);
        check("t5_dout_reset",  bus.slot_dout, 32'h0);
        bus.slot_cs = 1'b0;
        rst_n       = 1'b1;
        tick();
        saved = req_cnt;
        beats(16'h5555, 16'h6666);
        tick();
        check("t5_stray_dout", bus.slot_dout, 32'h0);
        check("t5_stray_no_req", req_cnt, saved);
        exp_req_q.push_back(22'h22);
        exp_ok_q.push_back(32'hFFFF_EEEE);
        bus.slot_addr = 17'h00011;
        bus.slot_cs   = 1'b1;
        #1;
        check("t5_invalid_after_reset", {31'h0, bus.slot_ok}, 32'h0);
        wait_req("t5_refetch");
        ack();
        beats(16'hEEEE, 16'hFFFF);
        tick();

        // 6: top word address, SDRAM address map at the wrap boundary
        exp_req_q.push_back(22'h3FFFE);
        exp_ok_q.push_back(32'h0304_0102);
`ifdef JTCOP_OBJROM_PREFETCH_EN
        exp_req_q.push_back(22'h0);
`endif
        bus.slot_addr = 17'h1FFFF;
        wait_req("t6_req");
        ack();
        beats(16'h0102, 16'h0304);
        check("t6_ok", {31'h0, bus.slot_ok}, 32'h1);
`ifdef JTCOP_OBJROM_PREFETCH_EN
        wait_req("t6_prefetch");
        ack();
        beats(16'h0506, 16'h0708);
        check("t6_ok_during_pf", {31'h0, bus.slot_ok}, 32'h1);
        tick();
        saved = req_cnt;
        exp_ok_q.push_back(32'h0708_0506);
        exp_req_q.push_back(22'h2);
        bus.slot_addr = 17'h00000;
        #1;
        check("t6_hit_b_same_cycle", {31'h0, bus.slot_ok}, 32'h1);
        check("t6_hit_no_demand_req", req_cnt, saved);
        wait_req("t6_next_prefetch");
        ack();
        beats(16'h090A, 16'h0B0C);
        check("t6_ok_after_swap", bus.slot_dout, 32'h0708_0506);
`else
        saved = req_cnt;
        repeat (5) tick();
        check("t6_no_prefetch", req_cnt, saved);
`endif
        bus.slot_cs = 1'b0;
        repeat (3) tick();
        check("req_queue_drained", exp_req_q.size(), 0);
        check("ok_queue_drained",  exp_ok_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
